// File: rtl/fmap_stream_tx.sv
// Frame-buffered 8-lane pixel transmitter: captures one IMG_W x IMG_H frame,
// then replays it in raster order with programmable gaps, hold and zero flush.
module fmap_stream_tx #(
  parameter int IMG_W      = 28,
  parameter int IMG_H      = 28,
  parameter int CH         = 8,
  parameter int GAP        = 0,
  parameter int FLUSH_PIX  = 0,
  parameter int AUTO_START = 0
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       in_valid,
  input  logic [7:0] in_data0,
  input  logic [7:0] in_data1,
  input  logic [7:0] in_data2,
  input  logic [7:0] in_data3,
  input  logic [7:0] in_data4,
  input  logic [7:0] in_data5,
  input  logic [7:0] in_data6,
  input  logic [7:0] in_data7,
  output logic       in_ready,
  input  logic       start,
  input  logic       hold,
  output logic       out_valid,
  output logic [7:0] out_data0,
  output logic [7:0] out_data1,
  output logic [7:0] out_data2,
  output logic [7:0] out_data3,
  output logic [7:0] out_data4,
  output logic [7:0] out_data5,
  output logic [7:0] out_data6,
  output logic [7:0] out_data7,
  output logic       busy,
  output logic       frame_done,
  output logic       overflow
);

  localparam int N     = IMG_W * IMG_H;
  localparam int PW    = (N > 1) ? $clog2(N) : 1;
  localparam int DW    = CH * 8;
  localparam int GW    = (GAP > 0) ? $clog2(GAP + 1) : 1;
  localparam int FW    = (FLUSH_PIX > 1) ? $clog2(FLUSH_PIX) : 1;
  localparam int FLAST = (FLUSH_PIX > 0) ? FLUSH_PIX - 1 : 0;
  localparam logic [PW-1:0] LAST_PTR = PW'(N - 1);

  typedef enum logic [2:0] {S_FILL, S_WAIT, S_SEND, S_FLUSH, S_DONE} state_t;

  state_t          r_state;
  logic [DW-1:0]   r_mem [N];
  logic [PW-1:0]   r_wr_ptr;
  logic [PW-1:0]   r_rd_ptr;
  logic [FW-1:0]   r_flush_cnt;
  logic [GW-1:0]   r_gap;
  logic            r_out_valid;
  logic [DW-1:0]   r_out_data;
  logic            r_frame_done;
  logic            r_busy;
  logic            r_in_ready;
  logic            r_overflow;

  logic [DW-1:0]   w_word;
  logic            w_issue;

  assign w_word  = {in_data7, in_data6, in_data5, in_data4,
                    in_data3, in_data2, in_data1, in_data0};
  assign w_issue = ((r_state == S_SEND) || (r_state == S_FLUSH)) && !hold && (r_gap == '0);

  // Frame storage is not reset; wr_ptr returning to 0 makes the next fill overwrite it.
  always_ff @(posedge clk) begin
    if ((r_state == S_FILL) && in_valid)
      r_mem[r_wr_ptr] <= w_word;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= S_FILL;
      r_wr_ptr     <= '0;
      r_rd_ptr     <= '0;
      r_flush_cnt  <= '0;
      r_gap        <= '0;
      r_out_valid  <= 1'b0;
      r_out_data   <= '0;
      r_frame_done <= 1'b0;
      r_busy       <= 1'b0;
      r_in_ready   <= 1'b1;
      r_overflow   <= 1'b0;
    end else begin
      r_out_valid  <= 1'b0;
      r_frame_done <= 1'b0;

      if (in_valid && !r_in_ready)
        r_overflow <= 1'b1;

      // Clearing the gap in DONE keeps start-to-first-pixel latency fixed for the next frame.
      if (w_issue)
        r_gap <= GW'(GAP);
      else if (r_state == S_DONE)
        r_gap <= '0;
      else if (r_gap != '0)
        r_gap <= r_gap - 1'b1;

      case (r_state)
        S_FILL: begin
          if (in_valid) begin
            if (r_wr_ptr == LAST_PTR) begin
              r_wr_ptr   <= '0;
              r_in_ready <= 1'b0;
              if (AUTO_START != 0) begin
                r_state <= S_SEND;
                r_busy  <= 1'b1;
              end else begin
                r_state <= S_WAIT;
              end
            end else begin
              r_wr_ptr <= r_wr_ptr + 1'b1;
            end
          end
        end
        S_WAIT: begin
          if (start) begin
            r_state <= S_SEND;
            r_busy  <= 1'b1;
          end
        end
        S_SEND: begin
          if (w_issue) begin
            r_out_valid <= 1'b1;
            r_out_data  <= r_mem[r_rd_ptr];
            if (r_rd_ptr == LAST_PTR) begin
              r_rd_ptr <= '0;
              if (FLUSH_PIX > 0) begin
                r_state <= S_FLUSH;
              end else begin
                r_state <= S_DONE;
                r_busy  <= 1'b0;
              end
            end else begin
              r_rd_ptr <= r_rd_ptr + 1'b1;
            end
          end
        end
        S_FLUSH: begin
          if (w_issue) begin
            r_out_valid <= 1'b1;
            r_out_data  <= '0;
            if (r_flush_cnt == FW'(FLAST)) begin
              r_flush_cnt <= '0;
              r_state     <= S_DONE;
              r_busy      <= 1'b0;
            end else begin
              r_flush_cnt <= r_flush_cnt + 1'b1;
            end
          end
        end
        S_DONE: begin
          r_state      <= S_FILL;
          r_in_ready   <= 1'b1;
          r_frame_done <= 1'b1;
        end
        default: r_state <= S_FILL;
      endcase
    end
  end

  assign in_ready   = r_in_ready;
  assign out_valid  = r_out_valid;
  assign busy       = r_busy;
  assign frame_done = r_frame_done;
  assign overflow   = r_overflow;
  assign out_data0  = r_out_data[7:0];
  assign out_data1  = r_out_data[15:8];
  assign out_data2  = r_out_data[23:16];
  assign out_data3  = r_out_data[31:24];
  assign out_data4  = r_out_data[39:32];
  assign out_data5  = r_out_data[47:40];
  assign out_data6  = r_out_data[55:48];
  assign out_data7  = r_out_data[63:56];

endmodule
